// File: rtl/ysyx_22050078_idex_reg.sv
// ID/EX pipeline register: captures decoded instruction state for EXU,
// resolves stall / flush / bubble in fixed priority, and keeps saturating
// statistics counters for stalls, flushes and inserted bubbles.
module ysyx_22050078_idex_reg #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int ALUOP_W   = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_idex_bubble,
  input  logic                 i_idu_valid,
  input  logic [CPU_WIDTH-1:0] i_idu_pc,
  input  logic [31:0]          i_idu_inst,
  input  logic [CPU_WIDTH-1:0] i_idu_rs1_data,
  input  logic [CPU_WIDTH-1:0] i_idu_rs2_data,
  input  logic [CPU_WIDTH-1:0] i_idu_imm,
  input  logic [REG_ADDRW-1:0] i_idu_rd_addr,
  input  logic                 i_idu_rdwen,
  input  logic                 i_idu_lden,
  input  logic                 i_idu_sten,
  input  logic [ALUOP_W-1:0]   i_idu_aluop,
  input  logic                 i_idu_ldstbp,
  output logic                 o_exu_valid,
  output logic [CPU_WIDTH-1:0] o_exu_pc,
  output logic [31:0]          o_exu_inst,
  output logic [CPU_WIDTH-1:0] o_exu_rs1,
  output logic [CPU_WIDTH-1:0] o_exu_rs2,
  output logic [CPU_WIDTH-1:0] o_exu_imm,
  output logic [REG_ADDRW-1:0] o_exu_rd_addr,
  output logic                 o_exu_rdwen,
  output logic                 o_exu_lden,
  output logic                 o_exu_sten,
  output logic [ALUOP_W-1:0]   o_exu_aluop,
  output logic                 o_exu_ldstbp,
  output logic [CNT_W-1:0]     o_bubble_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  // addi x0, x0, 0 -- the canonical RISC-V NOP encoding
  localparam logic [31:0]      NOP_INST = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // A flush and a bubble in the same cycle collapse into one NOP
  logic load_nop;
  assign load_nop = i_flush | i_idex_bubble;

  // Pipeline fields: reset > stall (hold) > flush/bubble (NOP) > normal load
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_exu_valid   <= 1'b0;
      o_exu_pc      <= '0;
      o_exu_inst    <= NOP_INST;
      o_exu_rs1     <= '0;
      o_exu_rs2     <= '0;
      o_exu_imm     <= '0;
      o_exu_rd_addr <= '0;
      o_exu_rdwen   <= 1'b0;
      o_exu_lden    <= 1'b0;
      o_exu_sten    <= 1'b0;
      o_exu_aluop   <= '0;
      o_exu_ldstbp  <= 1'b0;
    end else if (i_stall) begin
      // hold every field while the LSU is busy
    end else if (load_nop) begin
      o_exu_valid   <= 1'b0;
      o_exu_pc      <= '0;
      o_exu_inst    <= NOP_INST;
      o_exu_rs1     <= '0;
      o_exu_rs2     <= '0;
      o_exu_imm     <= '0;
      o_exu_rd_addr <= '0;
      o_exu_rdwen   <= 1'b0;
      o_exu_lden    <= 1'b0;
      o_exu_sten    <= 1'b0;
      o_exu_aluop   <= '0;
      o_exu_ldstbp  <= 1'b0;
    end else begin
      // Data fields pass through untouched; only the side-effecting
      // enables are masked by valid so a non-instruction cannot commit.
      o_exu_valid   <= i_idu_valid;
      o_exu_pc      <= i_idu_pc;
      o_exu_inst    <= i_idu_inst;
      o_exu_rs1     <= i_idu_rs1_data;
      o_exu_rs2     <= i_idu_rs2_data;
      o_exu_imm     <= i_idu_imm;
      o_exu_rd_addr <= i_idu_rd_addr;
      o_exu_rdwen   <= i_idu_valid & i_idu_rdwen;
      o_exu_lden    <= i_idu_valid & i_idu_lden;
      o_exu_sten    <= i_idu_valid & i_idu_sten;
      o_exu_aluop   <= i_idu_aluop;
      o_exu_ldstbp  <= i_idu_valid & i_idu_ldstbp;
    end
  end

  // Statistics counters, same priority as the pipeline fields, saturating
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bubble_cnt <= '0;
      o_flush_cnt  <= '0;
      o_stall_cnt  <= '0;
    end else if (i_stall) begin
      if (o_stall_cnt != CNT_MAX) o_stall_cnt <= o_stall_cnt + CNT_ONE;
    end else if (i_flush) begin
      // only a real instruction counts as killed
      if (i_idu_valid && (o_flush_cnt != CNT_MAX)) o_flush_cnt <= o_flush_cnt + CNT_ONE;
    end else if (i_idex_bubble) begin
      if (o_bubble_cnt != CNT_MAX) o_bubble_cnt <= o_bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/ysyx_22050078_idex_reg.md
# ysyx_22050078_idex_reg

ID/EX pipeline register of the 5-stage core. It is the receiving end of the bypass unit's ID-side outputs: forwarded rs1/rs2 data, the load-use bubble request and the load+store bypass flag. It captures decoded instruction state at each clock edge and presents it to EXU. It also resolves hold (stall), kill (branch flush) and bubble insertion in a fixed priority, and keeps saturating event counters for simulation statistics.

## Interface
Parameters:
- CPU_WIDTH, 64, datapath / PC width
- REG_ADDRW, 5, register index width
- ALUOP_W, 5, ALU opcode width
- CNT_W, 32, statistics counter width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_stall  in  1  hold all state (multi-cycle LSU busy)
- i_flush  in  1  kill ID-stage instruction (taken branch/jump resolved by BRU)
- i_idex_bubble  in  1  load-use bubble request from bypass unit
- i_idu_valid  in  1  ID stage holds a real instruction
- i_idu_pc  in  CPU_WIDTH  ID-stage PC
- i_idu_inst  in  32  ID-stage instruction word
- i_idu_rs1_data, i_idu_rs2_data  in  CPU_WIDTH  forwarded operands from bypass unit
- i_idu_imm  in  CPU_WIDTH  decoded immediate
- i_idu_rd_addr  in  REG_ADDRW  destination register
- i_idu_rdwen, i_idu_lden, i_idu_sten  in  1  rd write / load / store enables
- i_idu_aluop  in  ALUOP_W  ALU operation
- i_idu_ldstbp  in  1  load+store bypass flag from bypass unit
- o_exu_valid, o_exu_pc, o_exu_inst, o_exu_rs1, o_exu_rs2, o_exu_imm, o_exu_rd_addr, o_exu_rdwen, o_exu_lden, o_exu_sten, o_exu_aluop, o_exu_ldstbp  out  (same widths)  registered copies for EXU / bypass
- o_bubble_cnt  out  CNT_W  bubbles inserted
- o_flush_cnt  out  CNT_W  valid instructions killed by flush
- o_stall_cnt  out  CNT_W  cycles held by i_stall

## Operation
- NOP state: valid=0, rdwen=lden=sten=ldstbp=0, aluop=0, rd_addr=0, pc=0, rs1=rs2=imm=0, inst=32'h0000_0013.
- Priority per edge, highest first:
  - reset: all outputs to NOP state, counters to 0.
  - i_stall: all pipeline fields hold; o_stall_cnt increments.
  - i_flush: load NOP; o_flush_cnt increments only when i_idu_valid=1.
  - i_idex_bubble: load NOP; o_bubble_cnt increments.
  - otherwise: load all i_idu_* fields.
- Fields are captured as presented. There is no gating other than control enables. o_exu_ldstbp follows i_idu_ldstbp only on a normal load.
- i_idu_valid=0 on a normal load forces rdwen/lden/sten/ldstbp to 0 in the captured state. The other fields are captured unchanged.
- Counters saturate at all-ones and do not wrap.
- i_flush and i_idex_bubble together in one cycle: a single NOP; only o_flush_cnt can increment.

## Timing
- Latency: 1 cycle from i_idu_* to o_exu_*. All outputs come straight from flops; there is no combinational input-to-output path.
- Reset is asynchronous: outputs go to the NOP state immediately on i_rst rising, with no clock required. Release is synchronous to i_clk via the top-level synchronizer.
- Reset asserted mid-stall or mid-flush: reset wins and the counters clear.
- Stall of N cycles: outputs are stable for N+1 cycles total and o_stall_cnt grows by N. The first edge after stall release applies flush/bubble/load normally.
- The bypass unit's bubble is combinational from o_exu_lden/o_exu_rd_addr. After a bubble, o_exu_lden=0, so the request drops the next cycle. Each load-use hazard therefore inserts exactly one NOP.

## Test plan
- Reset: assert i_rst between edges -> all outputs immediately NOP (inst=0x00000013, valid=0), counters 0; first edge after release with valid addi x5 at pc=0x80000000 -> o_exu_pc=0x80000000, o_exu_rd_addr=5, o_exu_rdwen=1.
- Load-use: ld x6 followed by add x7,x6,x6, bubble asserted for one cycle -> EX sequence ld, NOP, add; o_bubble_cnt=1; add captures forwarded rs1/rs2 on the cycle after the bubble.
- Load+store: ld x6 then sd x6 with i_idu_ldstbp=1 and no bubble -> sd captured with o_exu_ldstbp=1, o_exu_sten=1; next non-store instruction -> o_exu_ldstbp=0.
- Flush+bubble same cycle with i_idu_valid=1 -> one NOP; o_flush_cnt=1, o_bubble_cnt unchanged. Flush with i_idu_valid=0 -> NOP, o_flush_cnt unchanged.
- Stall priority: i_stall=1 for 3 cycles while i_flush=1 and new i_idu_* values change -> outputs hold the prior instruction, o_stall_cnt=3, o_flush_cnt=0; drop stall with flush still high -> NOP, o_flush_cnt=1.
- Saturation: force o_bubble_cnt to 0xFFFFFFFF via preloaded bubbles (or CNT_W=4 build: 16 bubbles) -> counter stays at all-ones.
